// File: rtl/clock_reset_seq_if.sv
// Host-facing signal bundle of the MMCM reset sequencer: lock input, host
// requests, staged reset outputs and lock-loss statistics.
interface clock_reset_seq_if #(
  parameter int NUM_STAGES = 3
);
  logic                  LOCKED;
  logic                  FORCE_RST;
  logic                  CLEAR;
  logic [NUM_STAGES-1:0] RST_OUT;
  logic                  READY;
  logic                  LOCK_LOST;
  logic [7:0]            LOCK_LOSS_CNT;

  modport master (
    output LOCKED, FORCE_RST, CLEAR,
    input  RST_OUT, READY, LOCK_LOST, LOCK_LOSS_CNT
  );

  modport slave (
    input  LOCKED, FORCE_RST, CLEAR,
    output RST_OUT, READY, LOCK_LOST, LOCK_LOSS_CNT
  );
endinterface

// File: rtl/clock_reset_seq.sv
// Qualifies MMCM LOCKED on the free-running board clock and releases staged
// resets once lock has been stable; tracks qualified lock losses for the host.
module clock_reset_seq #(
  parameter int NUM_STAGES    = 3,
  parameter int STABLE_CYCLES = 256,
  parameter int STAGE_GAP     = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  clock_reset_seq_if.slave   bus
);

  localparam int CNT_MAX = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES + 1) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    RELEASE,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_STAGES-1:0]  rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;
  logic                   lost_q, lost_d;
  logic [7:0]             loss_cnt_q, loss_cnt_d;
  logic                   locked_s;
  logic                   loss;

  always_comb begin
    locked_s   = sync_q[SYNC_STAGES-1];
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.LOCKED};
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    ready_d    = ready_q;
    lost_d     = lost_q;
    loss_cnt_d = loss_cnt_q;

    // Only a lock that has already released stage 0 counts as a loss.
    loss = ((state_q == RELEASE) || (state_q == RUN)) && !locked_s;

    // Clear first so a simultaneous loss leaves a count of one.
    if (bus.CLEAR) begin
      lost_d     = 1'b0;
      loss_cnt_d = 8'd0;
    end
    if (loss) begin
      lost_d = 1'b1;
      if (loss_cnt_d != 8'hFF) begin
        loss_cnt_d = loss_cnt_d + 8'd1;
      end
    end

    if (loss || bus.FORCE_RST) begin
      state_d   = WAIT_LOCK;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          rst_out_d = '1;
          ready_d   = 1'b0;
          cnt_d     = '0;
          if (locked_s) begin
            state_d = STABILIZE;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            cnt_d        = '0;
            idx_d        = IDX_W'(1);
            rst_out_d[0] = 1'b0;
            if (NUM_STAGES == 1) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + IDX_W'(1);
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (IDX_W'(k) == idx_q) begin
                rst_out_d[k] = 1'b0;
              end
            end
            if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
              state_d = RUN;
              ready_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q     <= '0;
      state_q    <= WAIT_LOCK;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      ready_q    <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      ready_q    <= ready_d;
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign bus.RST_OUT       = rst_out_q;
  assign bus.READY         = ready_q;
  assign bus.LOCK_LOST     = lost_q;
  assign bus.LOCK_LOSS_CNT = loss_cnt_q;

endmodule

// File: tb/tb_clock_reset_seq.sv
// Scoreboard bench for clock_reset_seq: a time-based reference model predicts
// outputs per edge, a monitor compares them against the DUT.
module tb_clock_reset_seq;

  localparam int NUM    = 3;
  localparam int STABLE = 24;
  localparam int GAP    = 5;
  localparam int SYNC   = 3;

  typedef struct {
    logic [NUM-1:0] rst;
    logic           ready;
    logic           lost;
    logic [7:0]     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  clock_reset_seq_if #(.NUM_STAGES(NUM)) bus ();

  clock_reset_seq #(
    .NUM_STAGES   (NUM),
    .STABLE_CYCLES(STABLE),
    .STAGE_GAP    (GAP),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .CLK  (clk),
    .RESET(RESET),
    .bus  (bus)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: LOCKED history, edge index at which the qualified run of
  // lock began (-1 = waiting), and the host-visible statistics.
  logic lk_hist[$];
  int   m_start = -1;
  int   m_cnt   = 0;
  bit   m_lost  = 1'b0;
  int   cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge-check %0d: got %0h expected %0h", nm, checks, act, req);
    end
  endtask

  task automatic step(input bit lk, input bit fr, input bit cl, input bit rs);
    exp_t e;
    bit   ls;
    bit   loss;
    int   j;
    @(negedge clk);
    bus.LOCKED    = lk;
    bus.FORCE_RST = fr;
    bus.CLEAR     = cl;
    RESET         = rs;
    if (rs) begin
      lk_hist.delete();
      for (int i = 0; i < SYNC; i++) lk_hist.push_back(1'b0);
      m_start = -1;
      m_cnt   = 0;
      m_lost  = 1'b0;
    end else begin
      ls   = lk_hist[SYNC-1];
      j    = cyc - m_start;
      loss = (m_start >= 0) && (j > STABLE) && !ls;
      if (cl) begin
        m_cnt  = 0;
        m_lost = 1'b0;
      end
      if (loss) begin
        m_lost = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
      if (loss || fr) m_start = -1;
      else if (m_start >= 0 && !ls) m_start = -1;
      else if (m_start < 0 && ls) m_start = cyc;
      lk_hist.push_front(lk);
      void'(lk_hist.pop_back());
    end
    e.rst   = '1;
    e.ready = 1'b0;
    if (m_start >= 0) begin
      j = cyc - m_start;
      for (int k = 0; k < NUM; k++) begin
        if (j >= STABLE + k * GAP) e.rst[k] = 1'b0;
      end
      e.ready = (j >= STABLE + (NUM - 1) * GAP);
    end
    e.lost = m_lost;
    e.cnt  = 8'(m_cnt);
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic hold(input bit lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0, 1'b0, 1'b0);
  endtask

  exp_t mon_e;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("RST_OUT",       32'(bus.RST_OUT),       32'(mon_e.rst));
      chk("READY",         32'(bus.READY),         32'(mon_e.ready));
      chk("LOCK_LOST",     32'(bus.LOCK_LOST),     32'(mon_e.lost));
      chk("LOCK_LOSS_CNT", 32'(bus.LOCK_LOSS_CNT), 32'(mon_e.cnt));
    end
  end

  localparam int FULL = SYNC + STABLE + (NUM - 1) * GAP + 4;

  initial begin
    bit lk;
    int hold_n;
    bus.LOCKED    = 1'b0;
    bus.FORCE_RST = 1'b0;
    bus.CLEAR     = 1'b0;
    RESET         = 1'b1;
    for (int i = 0; i < SYNC; i++) lk_hist.push_back(1'b0);

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    hold(1'b0, 4);

    // Clean power-up release
    hold(1'b1, FULL + 5);

    // Single-cycle drop in RUN, then full re-release
    hold(1'b0, 1);
    hold(1'b1, FULL + 3);

    // Glitch while stabilizing is not counted
    step(1'b0, 1'b0, 1'b0, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 3);
    hold(1'b1, FULL);

    // Drive the loss counter well past saturation
    for (int n = 0; n < 300; n++) begin
      hold(1'b0, 1);
      hold(1'b1, SYNC + STABLE + 2);
    end
    hold(1'b1, 2 * GAP * NUM);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    hold(1'b1, 3);

    // CLEAR landing on the same edge as a loss
    hold(1'b0, 1);
    hold(1'b1, SYNC - 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    hold(1'b1, FULL);

    // Host-forced restart from RUN, and FORCE coinciding with a loss
    step(1'b1, 1'b1, 1'b0, 1'b0);
    hold(1'b1, FULL);
    hold(1'b0, 1);
    hold(1'b1, SYNC - 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    hold(1'b1, FULL);

    // RESET in the middle of the staged release
    step(1'b1, 1'b1, 1'b0, 1'b0);
    hold(1'b1, 2 + STABLE + GAP + 1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    hold(1'b1, FULL);

    // Randomized lock behaviour and host requests
    lk = 1'b1;
    hold_n = 0;
    for (int i = 0; i < 6000; i++) begin
      if (hold_n == 0) begin
        lk = ~lk;
        hold_n = lk ? int'($urandom_range(1, 2 * FULL)) : int'($urandom_range(1, 6));
      end
      hold_n--;
      step(lk, ($urandom_range(0, 199) == 0), ($urandom_range(0, 149) == 0),
           ($urandom_range(0, 999) == 0));
    end

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
